// File: rtl/multi_channel_divider.sv
// -----------------------------------------------------------------------------
// multi_channel_divider
//
// N-channel programmable clock divider. Each channel counts input clock edges
// and produces a registered divided output with a runtime-programmable period
// (P) and high time (H). Configuration writes land in a pending register per
// channel. The pending values are copied into the active registers:
//   - on the wrap edge of that channel,
//   - on every edge while the channel is idle (active P < 2),
//   - on sync_restart, which also phase-aligns every channel.
//
// Optional feature (compile-time macro DIVIDER_PHASE_EN):
//   When defined, cfg_sel=2 writes a per-channel pending phase. On sync_restart
//   the counter loads that phase (0 if the phase is not below the new period),
//   and the output is preloaded to (loaded count < H).
//   When undefined, there are no phase registers, cfg_sel=2 is ignored, and
//   sync_restart always loads the counter with 0.
//
// Parameters
//   CHANNELS        number of independent channels (1..16)
//   WIDTH           width of period / high / phase / counter registers
//   DEFAULT_PERIOD  period loaded into every channel on reset
//   DEFAULT_HIGH    high time loaded into every channel on reset
//
// Ports
//   pulse_clock     in   sole clock, rising edge
//   external_reset  in   asynchronous active-high reset
//   enable          in   global count enable; low freezes counters and outputs
//   sync_restart    in   single-cycle pulse; restart all channels aligned
//   cfg_wr          in   configuration write strobe
//   cfg_chan        in   target channel of the write
//   cfg_sel         in   0 = period, 1 = high time, 2 = phase, 3 = reserved
//   cfg_data        in   value written
//   divided_clock   out  per-channel divided output (registered)
//   period_tick     out  per-channel one-cycle pulse on the wrap edge
// -----------------------------------------------------------------------------
module multi_channel_divider #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 10,
    parameter int DEFAULT_HIGH   = 5,
    localparam int CHAN_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                pulse_clock,
    input  logic                external_reset,
    input  logic                enable,
    input  logic                sync_restart,
    input  logic                cfg_wr,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_sel,
    input  logic [WIDTH-1:0]    cfg_data,
    output logic [CHANNELS-1:0] divided_clock,
    output logic [CHANNELS-1:0] period_tick
);

    localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] RST_HIGH   = WIDTH'(DEFAULT_HIGH);
    localparam logic [WIDTH-1:0] ZERO       = '0;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO        = WIDTH'(2);

    localparam logic [1:0] SEL_PERIOD = 2'd0;
    localparam logic [1:0] SEL_HIGH   = 2'd1;
    localparam logic [1:0] SEL_PHASE  = 2'd2;

    // Channel indices beyond CHANNELS-1 are silently dropped (only reachable
    // when CHANNELS is not a power of two).
    logic cfg_hit;
    assign cfg_hit = cfg_wr && (int'(cfg_chan) < CHANNELS);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan

        logic             chan_sel;
        logic [WIDTH-1:0] pend_p_q, pend_p_d;
        logic [WIDTH-1:0] pend_h_q, pend_h_d;
        logic [WIDTH-1:0] act_p_q,  act_p_d;
        logic [WIDTH-1:0] act_h_q,  act_h_d;
        logic [WIDTH-1:0] cnt_q,    cnt_d;
        logic             div_q,    div_d;
        logic             tick_q,   tick_d;
        logic             idle;
        logic             wrap;
        logic [WIDTH-1:0] last_cnt;
        logic [WIDTH-1:0] restart_cnt;
        logic             restart_div;

        assign chan_sel = cfg_hit && (int'(cfg_chan) == c);

        // A period below 2 cannot produce a toggling output, so the channel
        // parks. last_cnt is only consumed when not idle, so P-1 never wraps.
        assign idle     = (act_p_q < TWO);
        assign last_cnt = act_p_q - ONE;
        assign wrap     = !idle && (cnt_q == last_cnt);

`ifdef DIVIDER_PHASE_EN
        logic [WIDTH-1:0] pend_ph_q, pend_ph_d;

        always_comb begin
            pend_ph_d = pend_ph_q;
            if (chan_sel && (cfg_sel == SEL_PHASE)) begin
                pend_ph_d = cfg_data;
            end
        end

        always_ff @(posedge pulse_clock or posedge external_reset) begin
            if (external_reset) begin
                pend_ph_q <= ZERO;
            end else begin
                pend_ph_q <= pend_ph_d;
            end
        end

        // Restart uses the pre-write pending values (the registers, not the
        // next-state), so a write on the restart edge only reaches pending.
        // An out-of-range phase or an idle new period falls back to 0.
        always_comb begin
            restart_cnt = ZERO;
            if ((pend_p_q >= TWO) && (pend_ph_q < pend_p_q)) begin
                restart_cnt = pend_ph_q;
            end
        end
        assign restart_div = (pend_p_q >= TWO) && (restart_cnt < pend_h_q);
`else
        assign restart_cnt = ZERO;
        assign restart_div = 1'b0;
`endif

        // Pending registers: written by the config port only.
        always_comb begin
            pend_p_d = pend_p_q;
            pend_h_d = pend_h_q;
            if (chan_sel) begin
                case (cfg_sel)
                    SEL_PERIOD: pend_p_d = cfg_data;
                    SEL_HIGH:   pend_h_d = cfg_data;
                    default:    ;
                endcase
            end
        end

        // Counter / output / shadow-load next state. Priority:
        // restart > idle > enabled counting > frozen.
        always_comb begin
            act_p_d = act_p_q;
            act_h_d = act_h_q;
            cnt_d   = cnt_q;
            div_d   = div_q;
            tick_d  = 1'b0;
            if (sync_restart) begin
                act_p_d = pend_p_q;
                act_h_d = pend_h_q;
                cnt_d   = restart_cnt;
                div_d   = restart_div;
            end else if (idle) begin
                act_p_d = pend_p_q;
                act_h_d = pend_h_q;
                cnt_d   = ZERO;
                div_d   = 1'b0;
            end else if (enable) begin
                cnt_d  = wrap ? ZERO : (cnt_q + ONE);
                // Output lags the counter by one edge: cnt=0 gives the first
                // high cycle. H=0 stays low, H>=P stays high.
                div_d  = (cnt_q < act_h_q);
                tick_d = wrap;
                if (wrap) begin
                    act_p_d = pend_p_q;
                    act_h_d = pend_h_q;
                end
            end
        end

        always_ff @(posedge pulse_clock or posedge external_reset) begin
            if (external_reset) begin
                pend_p_q <= RST_PERIOD;
                pend_h_q <= RST_HIGH;
                act_p_q  <= RST_PERIOD;
                act_h_q  <= RST_HIGH;
                cnt_q    <= ZERO;
                div_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                pend_p_q <= pend_p_d;
                pend_h_q <= pend_h_d;
                act_p_q  <= act_p_d;
                act_h_q  <= act_h_d;
                cnt_q    <= cnt_d;
                div_q    <= div_d;
                tick_q   <= tick_d;
            end
        end

        assign divided_clock[c] = div_q;
        assign period_tick[c]   = tick_q;
    end

endmodule

// File: tb/tb_multi_channel_divider.sv
module tb_multi_channel_divider;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        sync_restart;
    logic        cfg_wr;
    logic [1:0]  cfg_chan;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic [3:0]  divided_clock;
    logic [3:0]  period_tick;

    int n_cmp = 0;
    int n_err = 0;

    multi_channel_divider #(
        .CHANNELS(4), .WIDTH(16), .DEFAULT_PERIOD(10), .DEFAULT_HIGH(5)
    ) dut (
        .pulse_clock    (clk),
        .external_reset (rst),
        .enable         (enable),
        .sync_restart   (sync_restart),
        .cfg_wr         (cfg_wr),
        .cfg_chan       (cfg_chan),
        .cfg_sel        (cfg_sel),
        .cfg_data       (cfg_data),
        .divided_clock  (divided_clock),
        .period_tick    (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [3:0] mask,
                            input logic [3:0] ed, input logic [3:0] et);
        step();
        chk({tag, "_div"},  divided_clock & mask, ed & mask);
        chk({tag, "_tick"}, period_tick & mask,   et & mask);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] d);
        cfg_wr   = 1'b1;
        cfg_chan = ch;
        cfg_sel  = sel;
        cfg_data = d;
    endtask

    task automatic no_wr();
        cfg_wr   = 1'b0;
        cfg_chan = 2'd0;
        cfg_sel  = 2'd0;
        cfg_data = 16'd0;
    endtask

    // Defaults 10/5: after edge k (k=1..10 from cnt=0)
    logic [3:0] t1d [10] = '{4'hF,4'hF,4'hF,4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0};
    logic [3:0] t1t [10] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'hF};
    // Edges 21..42: ch1 reprogrammed to 4/1 mid-period
    logic [3:0] t2d [22] = '{4'hF,4'hF,4'hF,4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0,
                             4'hF,4'hD,4'hD,4'hD,4'hF,4'h0,4'h0,4'h0,4'h2,4'h0,4'hD,4'hD};
    logic [3:0] t2t [22] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'hF,
                             4'h0,4'h0,4'h0,4'h2,4'h0,4'h0,4'h0,4'h2,4'h0,4'hD,4'h0,4'h2};
    // Edges 43..62, ch2 only (bit 2)
    logic [3:0] t3d [20] = '{4'h4,4'h4,4'h4,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,
                             4'h0,4'h0,4'h0,4'h0,4'h4,4'h4,4'h4,4'h4,4'h4,4'h4};
    logic [3:0] t3t [20] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h4,4'h0,4'h0,
                             4'h0,4'h0,4'h0,4'h4,4'h0,4'h0,4'h0,4'h0,4'h0,4'h4};
    // Edges 63..74, ch0 only, enable low on edges 64..66
    logic [3:0] t4d [12] = '{4'h1,4'h1,4'h1,4'h1,4'h1,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0,4'h1};
    logic [3:0] t4t [12] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h1,4'h0};
    // Edges 77..86: restart edge then aligned run
    logic [3:0] t5d [10] = '{4'h0,4'hF,4'hD,4'h5,4'h5,4'hF,4'hE,4'h6,4'h4,4'hF};
    logic [3:0] t5t [10] = '{4'h0,4'h0,4'h0,4'h0,4'hA,4'h0,4'h4,4'h0,4'hB,4'h0};
    // Edges 87..93, ch2 only: idle period and reload
    logic [3:0] t7d [7]  = '{4'h4,4'h4,4'h4,4'h0,4'h0,4'h0,4'h4};
    logic [3:0] t7t [7]  = '{4'h0,4'h0,4'h4,4'h0,4'h0,4'h0,4'h0};
`ifdef DIVIDER_PHASE_EN
    logic [3:0] t6d [10] = '{4'h3,4'h3,4'h3,4'h1,4'h1,4'h0,4'h0,4'h2,4'h2,4'h3};
    logic [3:0] t6t [10] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h2,4'h0,4'h1,4'h0};
    logic [3:0] t6bd [6] = '{4'h3,4'h3,4'h3,4'h3,4'h3,4'h0};
`else
    logic [3:0] t6d [9]  = '{4'h0,4'h3,4'h3,4'h3,4'h3,4'h0,4'h0,4'h0,4'h0};
    logic [3:0] t6t [9]  = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h3};
`endif

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        sync_restart = 1'b0;
        no_wr();

        // Reset state
        step();
        step();
        chk("reset_div",  divided_clock, 4'h0);
        chk("reset_tick", period_tick,   4'h0);

        // 1: defaults, 5 high / 5 low, tick every 10
        rst    = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step_chk($sformatf("t1_e%0d", k + 1), 4'hF, t1d[k % 10], t1t[k % 10]);
        end

        // 2: ch1 P=4 H=1 written mid-period
        for (int i = 0; i < 22; i++) begin
            if (i == 3)      wr(2'd1, 2'd0, 16'd4);
            else if (i == 4) wr(2'd1, 2'd1, 16'd1);
            else             no_wr();
            step_chk($sformatf("t2_e%0d", 21 + i), 4'hF, t2d[i], t2t[i]);
        end

        // 3: ch2 P=6 H=0 (constant low), then H=7 (constant high)
        for (int i = 0; i < 20; i++) begin
            if (i == 0)      wr(2'd2, 2'd0, 16'd6);
            else if (i == 1) wr(2'd2, 2'd1, 16'd0);
            else if (i == 9) wr(2'd2, 2'd1, 16'd7);
            else             no_wr();
            step_chk($sformatf("t3_e%0d", 43 + i), 4'h4, t3d[i], t3t[i]);
        end

        // 4: enable low for 3 clocks during ch0 high phase; writes still land
        for (int i = 0; i < 12; i++) begin
            enable = !(i >= 1 && i <= 3);
            if (i == 2)      wr(2'd3, 2'd0, 16'd4);
            else if (i == 3) wr(2'd3, 2'd1, 16'd2);
            else             no_wr();
            step_chk($sformatf("t4_e%0d", 63 + i), 4'h1, t4d[i], t4t[i]);
            if (i >= 1 && i <= 3) begin
                chk($sformatf("t4_frozen_tick_e%0d", 63 + i), period_tick, 4'h0);
            end
        end
        enable = 1'b1;

        // 5: ch0 P=8, ch3 P=4 H=2, restart; ch1 H=3 written on the restart edge
        wr(2'd0, 2'd0, 16'd8);
        step();
        no_wr();
        step();
        sync_restart = 1'b1;
        wr(2'd1, 2'd1, 16'd3);
        step_chk("t5_e77", 4'hF, t5d[0], t5t[0]);
        sync_restart = 1'b0;
        no_wr();
        for (int i = 1; i < 10; i++) begin
            step_chk($sformatf("t5_e%0d", 77 + i), 4'hF, t5d[i], t5t[i]);
        end

        // Idle period (P=1), reserved select ignored, reload while idle
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      wr(2'd2, 2'd0, 16'd1);
            else if (i == 1) wr(2'd2, 2'd3, 16'd0);
            else if (i == 4) wr(2'd2, 2'd0, 16'd6);
            else             no_wr();
            step_chk($sformatf("t7_e%0d", 87 + i), 4'h4, t7d[i], t7t[i]);
        end
        no_wr();

        // 6: phase offset (or phase select ignored in the default build)
        wr(2'd1, 2'd0, 16'd8); step();
        wr(2'd1, 2'd1, 16'd4); step();
        wr(2'd1, 2'd2, 16'd2); step();
        wr(2'd0, 2'd1, 16'd4); step();
        no_wr();
        sync_restart = 1'b1;
`ifdef DIVIDER_PHASE_EN
        for (int i = 0; i < 10; i++) begin
            step_chk($sformatf("t6_r%0d", i), 4'h3, t6d[i], t6t[i]);
            sync_restart = 1'b0;
        end
        wr(2'd1, 2'd2, 16'd9); step();
        no_wr();
        sync_restart = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_chk($sformatf("t6b_r%0d", i), 4'h3, t6bd[i], 4'h0);
            sync_restart = 1'b0;
        end
`else
        for (int i = 0; i < 9; i++) begin
            step_chk($sformatf("t6_r%0d", i), 4'h3, t6d[i], t6t[i]);
            sync_restart = 1'b0;
        end
`endif

        // Reset mid-period: outputs drop without a clock edge, defaults return
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        step();
        chk("pre_reset_ch0_high", divided_clock & 4'h1, 4'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_div",  divided_clock, 4'h0);
        chk("async_reset_tick", period_tick,   4'h0);
        step();
        chk("held_reset_div", divided_clock, 4'h0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step_chk($sformatf("t8_e%0d", k + 1), 4'hF, t1d[k], t1t[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
